// File: rtl/imem_loader.sv
// imem_loader: boot-time program loader for the 5-stage MIPS core.
// Accepts a byte stream (valid/ready/last), packs big-endian 32-bit words
// and writes them sequentially into the instruction memory write port.
// The core is held in reset (cpu_reset_n=0) until a well-formed image is in.
// Optional feature macro: IMEM_LOADER_CHECKSUM_EN -- when defined, the in_last
// byte is an XOR checksum over all preceding image bytes instead of data.
module imem_loader #(
  parameter int ADDR_W = 5
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  input  logic              in_last,
  output logic              in_ready,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              cpu_reset_n,
  output logic              busy,
  output logic              error,
  output logic [ADDR_W:0]   words_loaded
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    DONE = 2'd2,
    ERR  = 2'd3
  } state_t;

  // Word count at which the memory is full; a further word is an overflow.
  localparam logic [ADDR_W:0] CAPACITY = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W:0] ONE_WORD = {{ADDR_W{1'b0}}, 1'b1};

  state_t              state_reg, state_next;
  logic [1:0]          byte_cnt_reg, byte_cnt_next;
  logic [23:0]         shift_reg, shift_next;   // first three bytes of the word being built
  logic                we_reg, we_next;
  logic [ADDR_W-1:0]   addr_reg, addr_next;
  logic [31:0]         wdata_reg, wdata_next;
  logic [ADDR_W:0]     words_reg, words_next;
  logic                in_ready_reg;
  logic                busy_reg;
  logic                error_reg;
  logic                cpu_run_reg;

  logic xfer;        // a byte moves this cycle
  logic data_byte;   // the moving byte belongs to the instruction data
  logic overflow;    // memory already holds CAPACITY words

  assign xfer     = in_valid && in_ready_reg;
  assign overflow = (words_reg == CAPACITY);

`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [7:0] csum_reg, csum_next;
  // The trailing checksum byte is not part of the image data.
  assign data_byte = xfer && !in_last;
`else
  assign data_byte = xfer;
`endif

  // State register; reset always returns to IDLE.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state and datapath decisions: byte packing, write issue, end-of-image checks.
  always_comb begin
    state_next    = state_reg;
    byte_cnt_next = byte_cnt_reg;
    shift_next    = shift_reg;
    we_next       = 1'b0;
    addr_next     = addr_reg;
    wdata_next    = wdata_reg;
    words_next    = words_reg;
`ifdef IMEM_LOADER_CHECKSUM_EN
    csum_next     = csum_reg;
`endif
    case (state_reg)
      IDLE, DONE, ERR: begin
        if (start) begin
          state_next    = LOAD;
          byte_cnt_next = 2'd0;
          words_next    = '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
          csum_next     = 8'h00;
`endif
        end
      end
      LOAD: begin
        // start is deliberately ignored while a load is in progress
        if (data_byte) begin
          shift_next    = {shift_reg[15:0], in_data};
          byte_cnt_next = byte_cnt_reg + 2'd1;
`ifdef IMEM_LOADER_CHECKSUM_EN
          csum_next     = csum_reg ^ in_data;
`endif
          if (byte_cnt_reg == 2'd3) begin
            if (overflow) begin
              // no room for this word: drop it and fail the load
              state_next = ERR;
            end else begin
              we_next    = 1'b1;
              addr_next  = words_reg[ADDR_W-1:0];
              wdata_next = {shift_reg, in_data};
              words_next = words_reg + ONE_WORD;
            end
          end
        end
        if (xfer && in_last) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
          // checksum must sit on a word boundary and match the running XOR
          state_next = ((byte_cnt_reg == 2'd0) && (in_data == csum_reg)) ? DONE : ERR;
`else
          // last byte must complete a word that actually fitted in memory
          state_next = ((byte_cnt_reg == 2'd3) && !overflow) ? DONE : ERR;
`endif
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Datapath and registered status outputs derived from the next state.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      byte_cnt_reg <= 2'd0;
      shift_reg    <= 24'h0;
      we_reg       <= 1'b0;
      addr_reg     <= '0;
      wdata_reg    <= 32'h0;
      words_reg    <= '0;
      in_ready_reg <= 1'b0;
      busy_reg     <= 1'b0;
      error_reg    <= 1'b0;
      cpu_run_reg  <= 1'b0;
    end else begin
      byte_cnt_reg <= byte_cnt_next;
      shift_reg    <= shift_next;
      we_reg       <= we_next;
      addr_reg     <= addr_next;
      wdata_reg    <= wdata_next;
      words_reg    <= words_next;
      in_ready_reg <= (state_next == LOAD);
      busy_reg     <= (state_next == LOAD);
      error_reg    <= (state_next == ERR);
      cpu_run_reg  <= (state_next == DONE);
    end
  end

`ifdef IMEM_LOADER_CHECKSUM_EN
  // Running XOR of every data byte of the current image.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      csum_reg <= 8'h00;
    end else begin
      csum_reg <= csum_next;
    end
  end
`endif

  assign in_ready     = in_ready_reg;
  assign imem_we      = we_reg;
  assign imem_addr    = addr_reg;
  assign imem_wdata   = wdata_reg;
  assign words_loaded = words_reg;
  assign busy         = busy_reg;
  assign error        = error_reg;
  assign cpu_reset_n  = cpu_run_reg;

endmodule
